// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: two 2-entry writeback FIFOs (ALU, load) share one write port.
// Define RR_ARB_EN for round-robin contention; otherwise the load FIFO wins contention.

module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ADDR_W-1:0]      push_rd,
  input  logic [DATA_W-1:0]      push_data,
  output logic [1:0]             count,
  output logic [ADDR_W-1:0]      head_rd,
  output logic [DATA_W-1:0]      head_data,
  output logic [2**ADDR_W-1:0]   mask
);
  logic [ADDR_W-1:0] rd_mem   [2];
  logic [DATA_W-1:0] data_mem [2];
  logic              rptr;
  logic              wptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rptr];
  assign head_data = data_mem[rptr];

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (count == 2'd2 || (count == 2'd1 && rptr == 1'(i)))
        mask[rd_mem[i]] = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 reg_write_enable,
  output logic                 grant_src,
  output logic [2**ADDR_W-1:0] pending_mask
);
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [1:0]           alu_count, mem_count;
  logic [ADDR_W-1:0]    alu_head_rd, mem_head_rd;
  logic [DATA_W-1:0]    alu_head_data, mem_head_data;
  logic [2**ADDR_W-1:0] alu_mask, mem_mask;
  logic                 alu_push, mem_push, alu_pop, mem_pop;
  logic                 grant;
  src_e                 grant_sel;

  assign alu_ready = rst_n && (alu_count < 2'd2);
  assign mem_ready = rst_n && (mem_count < 2'd2);

  // Writes to x0 complete the handshake but are never queued.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .push(alu_push), .pop(alu_pop),
    .push_rd(alu_rd), .push_data(alu_data), .count(alu_count),
    .head_rd(alu_head_rd), .head_data(alu_head_data), .mask(alu_mask)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .push(mem_push), .pop(mem_pop),
    .push_rd(mem_rd), .push_data(mem_data), .count(mem_count),
    .head_rd(mem_head_rd), .head_data(mem_head_data), .mask(mem_mask)
  );

`ifdef RR_ARB_EN
  src_e rr_prefer;

  // Pointer moves only on contended grants, handing preference to the loser.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_prefer <= SRC_ALU;
    else if (alu_count != 2'd0 && mem_count != 2'd0)
      rr_prefer <= (grant_sel == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end
`endif

  always_comb begin
    grant     = 1'b0;
    grant_sel = SRC_ALU;
    if (alu_count != 2'd0 && mem_count != 2'd0) begin
      grant = 1'b1;
`ifdef RR_ARB_EN
      grant_sel = rr_prefer;
`else
      grant_sel = SRC_MEM;
`endif
    end else if (alu_count != 2'd0) begin
      grant = 1'b1;
    end else if (mem_count != 2'd0) begin
      grant     = 1'b1;
      grant_sel = SRC_MEM;
    end
  end

  assign alu_pop = grant && (grant_sel == SRC_ALU);
  assign mem_pop = grant && (grant_sel == SRC_MEM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_reg        <= '0;
      write_data       <= '0;
      grant_src        <= 1'b0;
      reg_write_enable <= 1'b0;
    end else if (grant) begin
      write_reg        <= (grant_sel == SRC_MEM) ? mem_head_rd : alu_head_rd;
      write_data       <= (grant_sel == SRC_MEM) ? mem_head_data : alu_head_data;
      grant_src        <= (grant_sel == SRC_MEM);
      reg_write_enable <= 1'b1;
    end else begin
      reg_write_enable <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = alu_mask | mem_mask;
    if (reg_write_enable) pending_mask[write_reg] = 1'b1;
    pending_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expected values are hand-computed.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write_enable;
  logic        grant_src;
  logic [31:0] pending_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [4:0]  wq_rd   [$];
  logic [31:0] wq_data [$];
  logic        wq_src  [$];
  int          wq_cyc  [$];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_reg(write_reg), .write_data(write_data), .reg_write_enable(reg_write_enable),
    .grant_src(grant_src), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  // Every enable pulse lasts one cycle, so one sample per falling edge sees each write once.
  always @(negedge clk) begin
    cyc++;
    if (reg_write_enable === 1'b1) begin
      wq_rd.push_back(write_reg);
      wq_data.push_back(write_data);
      wq_src.push_back(grant_src);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [4:0] rd,
                             input logic [31:0] data, input logic src);
    if (idx < wq_rd.size()) begin
      check({tag, "_rd"}, 64'(wq_rd[idx]), 64'(rd));
      check({tag, "_data"}, 64'(wq_data[idx]), 64'(data));
      check({tag, "_src"}, 64'(wq_src[idx]), 64'(src));
    end else begin
      check({tag, "_missing"}, 64'(wq_rd.size()), 64'(idx + 1));
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_log();
    wq_rd.delete();
    wq_data.delete();
    wq_src.delete();
    wq_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    @(negedge clk);
    step(2);

    check("rst_we",     64'(reg_write_enable), 64'h0);
    check("rst_wreg",   64'(write_reg),        64'h0);
    check("rst_wdata",  64'(write_data),       64'h0);
    check("rst_src",    64'(grant_src),        64'h0);
    check("rst_mask",   64'(pending_mask),     64'h0);
    check("rst_aready", 64'(alu_ready),        64'h0);
    check("rst_mready", 64'(mem_ready),        64'h0);

    rst_n = 1'b1;
    #1;
    check("rel_aready", 64'(alu_ready), 64'h1);
    check("rel_mready", 64'(mem_ready), 64'h1);

    // Single ALU write rd=3 data=1.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    step();
    alu_valid = 1'b0;
    check("t1_q_mask", 64'(pending_mask),     64'h8);
    check("t1_q_we",   64'(reg_write_enable), 64'h0);
    step();
    check("t1_we",     64'(reg_write_enable), 64'h1);
    check("t1_wreg",   64'(write_reg),        64'h3);
    check("t1_wdata",  64'(write_data),       64'h1);
    check("t1_src",    64'(grant_src),        64'h0);
    check("t1_mask",   64'(pending_mask),     64'h8);
    step();
    check("t1_done_we",   64'(reg_write_enable), 64'h0);
    check("t1_done_mask", 64'(pending_mask),     64'h0);

    // x0 drop on the load port.
    clear_log();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
    #1;
    check("x0_ready", 64'(mem_ready), 64'h1);
    step();
    mem_valid = 1'b0;
    check("x0_mask", 64'(pending_mask), 64'h0);
    step(3);
    check("x0_nowrite", 64'(wq_rd.size()), 64'h0);
    check("x0_mask2",   64'(pending_mask), 64'h0);

    // Backpressure: three ALU pushes racing two loads (load wins contention in the default build).
    clear_log();
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB0;
    step();
    mem_rd = 5'd11; mem_data = 32'hA1;
    alu_rd = 5'd21; alu_data = 32'hB1;
    step();
`ifdef RR_ARB_EN
    check("bp_aready_full", 64'(alu_ready), 64'h1);
`else
    check("bp_aready_full", 64'(alu_ready), 64'h0);
    check("bp_mask", 64'(pending_mask), 64'h0030_0C00);
`endif
    mem_valid = 1'b0;
    alu_rd = 5'd22; alu_data = 32'hB2;
`ifndef RR_ARB_EN
    step();
    check("bp_aready_held", 64'(alu_ready), 64'h0);
    step();
    check("bp_aready_free", 64'(alu_ready), 64'h1);
`endif
    step();
    alu_valid = 1'b0;
    step(5);
    check("bp_count", 64'(wq_rd.size()), 64'd5);
`ifndef RR_ARB_EN
    check_write("bp_w0", 0, 5'd10, 32'hA0, 1'b1);
    check_write("bp_w1", 1, 5'd11, 32'hA1, 1'b1);
    check_write("bp_w2", 2, 5'd20, 32'hB0, 1'b0);
    check_write("bp_w3", 3, 5'd21, 32'hB1, 1'b0);
    check_write("bp_w4", 4, 5'd22, 32'hB2, 1'b0);
`endif

    // Contention: ALU rd 1,2 and load rd 5,6 pushed together.
    clear_log();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
    step();
    alu_rd = 5'd2; alu_data = 32'h22;
    mem_rd = 5'd6; mem_data = 32'h66;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    step(5);
    check("ct_count", 64'(wq_rd.size()), 64'd4);
`ifdef RR_ARB_EN
    check_write("ct_w0", 0, 5'd1, 32'h11, 1'b0);
    check_write("ct_w1", 1, 5'd5, 32'h55, 1'b1);
    check_write("ct_w2", 2, 5'd2, 32'h22, 1'b0);
    check_write("ct_w3", 3, 5'd6, 32'h66, 1'b1);
`else
    check_write("ct_w0", 0, 5'd5, 32'h55, 1'b1);
    check_write("ct_w1", 1, 5'd6, 32'h66, 1'b1);
    check_write("ct_w2", 2, 5'd1, 32'h11, 1'b0);
    check_write("ct_w3", 3, 5'd2, 32'h22, 1'b0);
`endif
    if (wq_cyc.size() == 4) check("ct_no_bubble", 64'(wq_cyc[3] - wq_cyc[0]), 64'd3);
    else check("ct_no_bubble_missing", 64'(wq_cyc.size()), 64'd4);

    // Streaming ALU pushes: push and pop together at count 1.
    clear_log();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    step();
    check("pp_ready0", 64'(alu_ready), 64'h1);
    alu_rd = 5'd5; alu_data = 32'h45;
    step();
    check("pp_ready1", 64'(alu_ready), 64'h1);
    check("pp_we1",    64'(reg_write_enable), 64'h1);
    check("pp_wreg1",  64'(write_reg), 64'd4);
    alu_rd = 5'd6; alu_data = 32'h46;
    step();
    check("pp_ready2", 64'(alu_ready), 64'h1);
    check("pp_mask2",  64'(pending_mask), 64'h60);
    alu_valid = 1'b0;
    step(3);
    check("pp_count", 64'(wq_rd.size()), 64'd3);
    check_write("pp_w0", 0, 5'd4, 32'h44, 1'b0);
    check_write("pp_w1", 1, 5'd5, 32'h45, 1'b0);
    check_write("pp_w2", 2, 5'd6, 32'h46, 1'b0);

    // Reset with queued entries, then a clean write after release.
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    step();
    alu_rd = 5'd12; alu_data = 32'hCC;
    mem_rd = 5'd13; mem_data = 32'hDD;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("mr_pre_mask", 64'(pending_mask), 64'h0000_3300);
    rst_n = 1'b0;
    step();
    clear_log();
    check("mr_we",     64'(reg_write_enable), 64'h0);
    check("mr_mask",   64'(pending_mask),     64'h0);
    check("mr_aready", 64'(alu_ready),        64'h0);
    check("mr_mready", 64'(mem_ready),        64'h0);
    step();
    rst_n = 1'b1;
    step(2);
    check("mr_nowrite", 64'(wq_rd.size()), 64'h0);
    check("mr_mask2",   64'(pending_mask), 64'h0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h2;
    step();
    alu_valid = 1'b0;
    step();
    check("mr_we2",   64'(reg_write_enable), 64'h1);
    check("mr_wreg2", 64'(write_reg),        64'd7);
    check("mr_data2", 64'(write_data),       64'h2);
    check("mr_src2",  64'(grant_src),        64'h0);
    check("mr_mask3", 64'(pending_mask),     64'h80);
    step();
    check("mr_we3", 64'(reg_write_enable), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
